// File: rtl/z80_dma_ctrl.sv
// z80_dma_ctrl: memory-to-memory DMA engine for the TV80 bus, CPU-programmed through an 8-register I/O window.
module z80_dma_ctrl #(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2,
  parameter int BURST = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs_n,
  input  logic [2:0]  io_addr,
  input  logic        io_wr_n,
  input  logic        io_rd_n,
  input  logic [7:0]  cpu_data_in,
  output logic [7:0]  cpu_data_out,
  output logic        busrq_n,
  input  logic        busak_n,
  output logic        bus_oe,
  output logic [15:0] addr_out,
  output logic [7:0]  data_out,
  input  logic [7:0]  data_in,
  output logic        mreq_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        irq_n
);
  localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_RD_ADDR = 3'd2, S_RD_STB = 3'd3,
                         S_WR_ADDR = 3'd4, S_WR_STB = 3'd5, S_WR_END = 3'd6, S_REL = 3'd7;
  localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LAST = 4'(WR_WAIT - 1);
  localparam logic [15:0] BL = 16'(BURST);
  logic [2:0] state;
  logic [15:0] src, dst, len, bcnt;
  logic [3:0] wcnt;
  logic [7:0] hold, reg_q;
  logic irq_en, src_fixed, dst_fixed, done, aborted, irq;
  logic reg_wr, ctrl_wr, busy, own, oe, lost, start, abort, unused_bits;
  assign reg_wr = !cs_n && !io_wr_n;
  assign ctrl_wr = reg_wr && io_addr == 3'd6;
  assign busy = state != S_IDLE;
  assign own = state >= S_RD_ADDR && state <= S_WR_END;
  assign oe = own && !busak_n;
  // Losing the grant mid-cycle drops every strobe before the next edge
  assign lost = own && busak_n;
  assign start = ctrl_wr && cpu_data_in[0] && !busy;
  assign abort = ctrl_wr && cpu_data_in[7] && (state == S_IDLE || state == S_REQ || state == S_REL);
  assign unused_bits = ^cpu_data_in[6:4];
  assign busrq_n = !(state == S_REQ || own);
  assign bus_oe = oe;
  assign addr_out = !oe ? 16'h0000 : (state <= S_RD_STB ? src : dst);
  assign data_out = (oe && state >= S_WR_ADDR) ? hold : 8'h00;
  assign mreq_n = !(oe && (state == S_RD_STB || state == S_WR_STB));
  assign rd_n = !(oe && state == S_RD_STB);
  assign wr_n = !(oe && state == S_WR_STB);
  assign irq_n = !irq;
  always_comb begin
    case (io_addr)
      3'd0: reg_q = src[7:0];
      3'd1: reg_q = src[15:8];
      3'd2: reg_q = dst[7:0];
      3'd3: reg_q = dst[15:8];
      3'd4: reg_q = len[7:0];
      3'd5: reg_q = len[15:8];
      3'd6: reg_q = {4'b0, dst_fixed, src_fixed, irq_en, 1'b0};
      default: reg_q = {5'b0, aborted, done, busy};
    endcase
  end
  assign cpu_data_out = (!cs_n && !io_rd_n) ? reg_q : 8'h00;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      src <= '0;
      dst <= '0;
      len <= '0;
      bcnt <= '0;
      wcnt <= '0;
      hold <= '0;
      irq_en <= 1'b0;
      src_fixed <= 1'b0;
      dst_fixed <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (reg_wr && !busy) begin
        case (io_addr)
          3'd0: src[7:0] <= cpu_data_in;
          3'd1: src[15:8] <= cpu_data_in;
          3'd2: dst[7:0] <= cpu_data_in;
          3'd3: dst[15:8] <= cpu_data_in;
          3'd4: len[7:0] <= cpu_data_in;
          3'd5: len[15:8] <= cpu_data_in;
          default: ;
        endcase
      end
      if (ctrl_wr) {dst_fixed, src_fixed, irq_en} <= cpu_data_in[3:1];
      if (reg_wr && io_addr == 3'd7) begin
        done <= 1'b0;
        aborted <= 1'b0;
        irq <= 1'b0;
      end
      // Completion updates below are ordered after the status clear so they win on a collision
      if (abort) begin
        state <= S_IDLE;
        aborted <= 1'b1;
        done <= 1'b0;
        if (cpu_data_in[1]) irq <= 1'b1;
      end else if (lost) state <= S_REQ;
      else begin
        case (state)
          S_IDLE: if (start) begin
            if (len != 16'd0) state <= S_REQ;
            else begin
              done <= 1'b1;
              if (cpu_data_in[1]) irq <= 1'b1;
            end
          end
          S_REQ: if (!busak_n) begin
            state <= S_RD_ADDR;
            bcnt <= '0;
          end
          S_RD_ADDR: begin
            wcnt <= '0;
            state <= S_RD_STB;
          end
          S_RD_STB: if (wcnt == RD_LAST) begin
            hold <= data_in;
            wcnt <= '0;
            state <= S_WR_ADDR;
          end else wcnt <= wcnt + 4'd1;
          S_WR_ADDR: state <= S_WR_STB;
          S_WR_STB: if (wcnt == WR_LAST) begin
            wcnt <= '0;
            state <= S_WR_END;
          end else wcnt <= wcnt + 4'd1;
          S_WR_END: begin
            src <= src_fixed ? src : src + 16'd1;
            dst <= dst_fixed ? dst : dst + 16'd1;
            len <= len - 16'd1;
            bcnt <= bcnt + 16'd1;
            if (len == 16'd1) begin
              state <= S_IDLE;
              done <= 1'b1;
              if (irq_en) irq <= 1'b1;
            end else state <= (BL != 16'd0 && bcnt + 16'd1 == BL) ? S_REL : S_RD_ADDR;
          end
          default: state <= S_REQ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_z80_dma_ctrl.sv
// tb_z80_dma_ctrl: randomized self-checking bench against a transfer-level reference model.
module tb_z80_dma_ctrl;
  logic clk = 0, reset_n = 0, cs_n = 1, io_wr_n = 1, io_rd_n = 1, busak_n = 1, sel = 0;
  logic [2:0] io_addr = 0;
  logic [7:0] cpu_data_in = 0, data_in;
  logic [7:0] a_cpu, b_cpu, a_dout, b_dout, m_cpu, m_dout;
  logic [15:0] a_addr, b_addr, m_addr;
  logic a_busrq_n, b_busrq_n, a_oe, b_oe, a_mreq_n, b_mreq_n, a_rd_n, b_rd_n, a_wr_n, b_wr_n, a_irq_n, b_irq_n;
  logic m_busrq_n, m_oe, m_mreq_n, m_rd_n, m_wr_n, m_irq_n, cs_a, cs_b, busak_a, busak_b;
  logic [7:0] mem [0:65535];
  int checks = 0, passed = 0;
  int gdelay = 0, gcnt = 0;
  bit arb_hold = 0;
  int oe_cycles, rd_cycles, falls, gap_bad, hi_run;
  logic prev_rd = 1, prev_wr = 1;
  logic [15:0] rd_log[$], exp_rd[$];
  logic [23:0] wr_log[$], exp_wr[$];
  logic [15:0] e_src, e_dst;

  assign cs_a = cs_n | sel;
  assign cs_b = cs_n | !sel;
  assign busak_a = sel ? 1'b1 : busak_n;
  assign busak_b = sel ? busak_n : 1'b1;
  assign m_cpu = sel ? b_cpu : a_cpu;
  assign m_dout = sel ? b_dout : a_dout;
  assign m_addr = sel ? b_addr : a_addr;
  assign m_busrq_n = sel ? b_busrq_n : a_busrq_n;
  assign m_oe = sel ? b_oe : a_oe;
  assign m_mreq_n = sel ? b_mreq_n : a_mreq_n;
  assign m_rd_n = sel ? b_rd_n : a_rd_n;
  assign m_wr_n = sel ? b_wr_n : a_wr_n;
  assign m_irq_n = sel ? b_irq_n : a_irq_n;
  assign data_in = mem[m_addr];

  z80_dma_ctrl u_a (.clk(clk), .reset_n(reset_n), .cs_n(cs_a), .io_addr(io_addr), .io_wr_n(io_wr_n),
    .io_rd_n(io_rd_n), .cpu_data_in(cpu_data_in), .cpu_data_out(a_cpu), .busrq_n(a_busrq_n),
    .busak_n(busak_a), .bus_oe(a_oe), .addr_out(a_addr), .data_out(a_dout), .data_in(data_in),
    .mreq_n(a_mreq_n), .rd_n(a_rd_n), .wr_n(a_wr_n), .irq_n(a_irq_n));
  z80_dma_ctrl #(.BURST(2)) u_b (.clk(clk), .reset_n(reset_n), .cs_n(cs_b), .io_addr(io_addr), .io_wr_n(io_wr_n),
    .io_rd_n(io_rd_n), .cpu_data_in(cpu_data_in), .cpu_data_out(b_cpu), .busrq_n(b_busrq_n),
    .busak_n(busak_b), .bus_oe(b_oe), .addr_out(b_addr), .data_out(b_dout), .data_in(data_in),
    .mreq_n(b_mreq_n), .rd_n(b_rd_n), .wr_n(b_wr_n), .irq_n(b_irq_n));

  always #5 clk = ~clk;

  // Bus arbiter: grants gdelay cycles after a request, drops the grant as soon as the request goes away
  always @(negedge clk) begin
    if (arb_hold || m_busrq_n) begin
      busak_n = 1;
      gcnt = 0;
    end else if (gcnt >= gdelay) busak_n = 0;
    else gcnt++;
  end

  always @(negedge clk) begin
    #1;
    if (m_oe) oe_cycles++;
    if (!m_rd_n) rd_cycles++;
    if (!m_rd_n && prev_rd) rd_log.push_back(m_addr);
    if (!m_wr_n && prev_wr) wr_log.push_back({m_addr, m_dout});
    prev_rd = m_rd_n;
    prev_wr = m_wr_n;
    if (m_busrq_n) hi_run++;
    else if (hi_run > 0) begin
      if (falls > 0 && hi_run != 1) gap_bad++;
      falls++;
      hi_run = 0;
    end
  end

  task automatic clr_mon();
    oe_cycles = 0; rd_cycles = 0; falls = 0; gap_bad = 0; hi_run = 0;
    rd_log.delete(); wr_log.delete();
  endtask

  task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    io_addr = a; cpu_data_in = d; cs_n = 0; io_wr_n = 0;
    @(negedge clk);
    cs_n = 1; io_wr_n = 1;
  endtask

  task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    io_addr = a; cs_n = 0; io_rd_n = 0;
    #1 d = m_cpu;
    cs_n = 1; io_rd_n = 1;
  endtask

  task automatic rd16(input logic [2:0] a, output logic [15:0] v);
    logic [7:0] lo, hi;
    cpu_rd(a, lo);
    cpu_rd(3'(a + 3'd1), hi);
    v = {hi, lo};
  endtask

  // Reference: byte i is read from SRC(+i) and its value lands at DST(+i); fixed pointers never move
  function automatic void model(input logic [15:0] s, d, n, input logic sf, df);
    exp_rd.delete(); exp_wr.delete();
    for (int i = 0; i < int'(n); i++) begin
      logic [15:0] ra, wa;
      ra = sf ? s : 16'(s + 16'(i));
      wa = df ? d : 16'(d + 16'(i));
      exp_rd.push_back(ra);
      exp_wr.push_back({wa, mem[ra]});
    end
    e_src = sf ? s : 16'(s + n);
    e_dst = df ? d : 16'(d + n);
  endfunction

  function automatic int rd_diff();
    int e = (rd_log.size() != exp_rd.size()) ? 1 : 0;
    foreach (exp_rd[i]) if (i >= rd_log.size() || rd_log[i] !== exp_rd[i]) e++;
    return e;
  endfunction

  function automatic int wr_diff();
    int e = (wr_log.size() != exp_wr.size()) ? 1 : 0;
    foreach (exp_wr[i]) if (i >= wr_log.size() || wr_log[i] !== exp_wr[i]) e++;
    return e;
  endfunction

  task automatic start_xfer(input logic [15:0] s, d, n, input logic ie, sf, df);
    cpu_wr(7, 0);
    cpu_wr(0, s[7:0]); cpu_wr(1, s[15:8]);
    cpu_wr(2, d[7:0]); cpu_wr(3, d[15:8]);
    cpu_wr(4, n[7:0]); cpu_wr(5, n[15:8]);
    model(s, d, n, sf, df);
    clr_mon();
    cpu_wr(6, {4'b0, df, sf, ie, 1'b1});
  endtask

  task automatic wait_idle(output bit ok);
    logic [7:0] st;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      cpu_rd(7, st);
      if (!st[0]) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    checks++; if (m_busrq_n !== 1'b1) $display("FAIL rst_busrq: got %b want 1", m_busrq_n); else passed++;
    checks++; if (m_oe !== 1'b0) $display("FAIL rst_oe: got %b want 0", m_oe); else passed++;
    checks++; if ({m_mreq_n, m_rd_n, m_wr_n} !== 3'b111) $display("FAIL rst_strobes: got %b want 111", {m_mreq_n, m_rd_n, m_wr_n}); else passed++;
    checks++; if (m_irq_n !== 1'b1) $display("FAIL rst_irq: got %b want 1", m_irq_n); else passed++;
    checks++; if ({m_addr, m_dout} !== 24'h0) $display("FAIL rst_addr_data: got %h want 000000", {m_addr, m_dout}); else passed++;
    checks++; if (m_cpu !== 8'h00) $display("FAIL rst_cpu_idle: got %h want 00", m_cpu); else passed++;
    for (int a = 0; a < 8; a++) begin
      cpu_rd(3'(a), v);
      checks++; if (v !== 8'h00) $display("FAIL rst_reg%0d: got %h want 00", a, v); else passed++;
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [7:0] st;
    logic [15:0] v;
    gdelay = 2;
    start_xfer(16'h0200, 16'h01F0, 16'd3, 0, 0, 0);
    wait_idle(ok);
    checks++; if (!ok) $display("FAIL basic_timeout: got busy want idle"); else passed++;
    checks++; if (rd_diff() != 0) $display("FAIL basic_reads: got %0d diffs (%0d reads) want 0", rd_diff(), rd_log.size()); else passed++;
    checks++; if (wr_diff() != 0) $display("FAIL basic_writes: got %0d diffs (%0d writes) want 0", wr_diff(), wr_log.size()); else passed++;
    checks++; if (oe_cycles != 21) $display("FAIL basic_bus_cycles: got %0d want 21", oe_cycles); else passed++;
    checks++; if (rd_cycles != 6) $display("FAIL basic_rd_cycles: got %0d want 6", rd_cycles); else passed++;
    checks++; if (falls != 1) $display("FAIL basic_tenures: got %0d want 1", falls); else passed++;
    cpu_rd(7, st);
    checks++; if (st !== 8'h02) $display("FAIL basic_status: got %h want 02", st); else passed++;
    checks++; if (m_irq_n !== 1'b1) $display("FAIL basic_irq: got %b want 1", m_irq_n); else passed++;
    rd16(0, v);
    checks++; if (v !== 16'h0203) $display("FAIL basic_src: got %h want 0203", v); else passed++;
    rd16(2, v);
    checks++; if (v !== 16'h01F3) $display("FAIL basic_dst: got %h want 01F3", v); else passed++;
    rd16(4, v);
    checks++; if (v !== 16'h0000) $display("FAIL basic_len: got %h want 0000", v); else passed++;
  endtask

  task automatic test_zero_len();
    logic [7:0] st;
    cpu_wr(7, 0); cpu_wr(4, 0); cpu_wr(5, 0);
    clr_mon();
    cpu_wr(6, 8'h01);
    cpu_rd(7, st);
    checks++; if (st !== 8'h02) $display("FAIL zero_status: got %h want 02", st); else passed++;
    repeat (5) @(negedge clk);
    checks++; if (falls != 0 || m_busrq_n !== 1'b1) $display("FAIL zero_busrq: got %0d requests want 0", falls); else passed++;
  endtask

  task automatic test_wrap();
    bit ok;
    logic [15:0] v;
    gdelay = 1;
    start_xfer(16'hFFFF, 16'h8000, 16'd2, 0, 0, 0);
    wait_idle(ok);
    checks++; if (!ok) $display("FAIL wrap_timeout: got busy want idle"); else passed++;
    checks++; if (rd_diff() != 0 || rd_log.size() != 2 || rd_log[1] !== 16'h0000) $display("FAIL wrap_reads: got %0d diffs want 0", rd_diff()); else passed++;
    checks++; if (wr_diff() != 0) $display("FAIL wrap_writes: got %0d diffs want 0", wr_diff()); else passed++;
    rd16(0, v);
    checks++; if (v !== 16'h0001) $display("FAIL wrap_src: got %h want 0001", v); else passed++;
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] st;
    logic [15:0] s, d, n, v;
    logic ie, sf, df;
    for (int k = 0; k < 6; k++) begin
      s = 16'($urandom); d = 16'($urandom); n = 16'($urandom_range(1, 6));
      {ie, sf, df} = 3'($urandom);
      gdelay = $urandom_range(0, 3);
      start_xfer(s, d, n, ie, sf, df);
      wait_idle(ok);
      checks++; if (!ok) $display("FAIL rand%0d_timeout: got busy want idle", k); else passed++;
      checks++; if (rd_diff() != 0) $display("FAIL rand%0d_reads: got %0d diffs want 0", k, rd_diff()); else passed++;
      checks++; if (wr_diff() != 0) $display("FAIL rand%0d_writes: got %0d diffs want 0", k, wr_diff()); else passed++;
      checks++; if (oe_cycles != 7 * int'(n)) $display("FAIL rand%0d_bus_cycles: got %0d want %0d", k, oe_cycles, 7 * int'(n)); else passed++;
      rd16(0, v);
      checks++; if (v !== e_src) $display("FAIL rand%0d_src: got %h want %h", k, v, e_src); else passed++;
      rd16(2, v);
      checks++; if (v !== e_dst) $display("FAIL rand%0d_dst: got %h want %h", k, v, e_dst); else passed++;
      cpu_rd(6, st);
      checks++; if (st !== {4'b0, df, sf, ie, 1'b0}) $display("FAIL rand%0d_ctrl: got %h want %h", k, st, {4'b0, df, sf, ie, 1'b0}); else passed++;
      checks++; if (m_irq_n !== !ie) $display("FAIL rand%0d_irq: got %b want %b", k, m_irq_n, !ie); else passed++;
      cpu_wr(7, 0);
      checks++; if (m_irq_n !== 1'b1) $display("FAIL rand%0d_irq_clr: got %b want 1", k, m_irq_n); else passed++;
    end
  endtask

  task automatic test_burst();
    bit ok;
    logic [15:0] v;
    sel = 1;
    gdelay = 1;
    start_xfer(16'($urandom), 16'h4000, 16'd5, 0, 0, 1);
    wait_idle(ok);
    checks++; if (!ok) $display("FAIL burst_timeout: got busy want idle"); else passed++;
    checks++; if (falls != 3) $display("FAIL burst_tenures: got %0d want 3", falls); else passed++;
    checks++; if (gap_bad != 0) $display("FAIL burst_gap: got %0d bad gaps want 0", gap_bad); else passed++;
    checks++; if (rd_diff() != 0) $display("FAIL burst_reads: got %0d diffs want 0", rd_diff()); else passed++;
    checks++; if (wr_diff() != 0) $display("FAIL burst_writes: got %0d diffs want 0", wr_diff()); else passed++;
    rd16(2, v);
    checks++; if (v !== 16'h4000) $display("FAIL burst_dst: got %h want 4000", v); else passed++;
    rd16(4, v);
    checks++; if (v !== 16'h0000) $display("FAIL burst_len: got %h want 0000", v); else passed++;
    sel = 0;
  endtask

  task automatic test_bus_loss();
    bit ok, seen;
    logic [15:0] s, v;
    s = 16'($urandom);
    gdelay = 1;
    start_xfer(s, 16'($urandom), 16'd3, 0, 0, 0);
    exp_rd.push_front(s);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = !m_rd_n;
    end
    checks++; if (!seen) $display("FAIL loss_rd_start: got rd_n high want low"); else passed++;
    @(posedge clk);
    #1 arb_hold = 1; busak_n = 1;
    #1;
    checks++; if ({m_mreq_n, m_rd_n, m_oe} !== 3'b110) $display("FAIL loss_strobes: got %b want 110", {m_mreq_n, m_rd_n, m_oe}); else passed++;
    repeat (3) @(negedge clk);
    arb_hold = 0;
    wait_idle(ok);
    checks++; if (!ok) $display("FAIL loss_timeout: got busy want idle"); else passed++;
    checks++; if (rd_diff() != 0) $display("FAIL loss_reads: got %0d diffs (%0d reads) want 0", rd_diff(), rd_log.size()); else passed++;
    checks++; if (wr_diff() != 0) $display("FAIL loss_writes: got %0d diffs want 0", wr_diff()); else passed++;
    rd16(4, v);
    checks++; if (v !== 16'h0000) $display("FAIL loss_len: got %h want 0000", v); else passed++;
  endtask

  task automatic test_abort();
    logic [7:0] st;
    logic [15:0] v;
    arb_hold = 1;
    start_xfer(16'h1000, 16'h2000, 16'd4, 1, 0, 0);
    repeat (3) @(negedge clk);
    checks++; if (m_busrq_n !== 1'b0) $display("FAIL abort_req: got %b want 0", m_busrq_n); else passed++;
    cpu_wr(4, 8'h55);
    cpu_wr(6, 8'h82);
    cpu_rd(7, st);
    checks++; if (st !== 8'h04) $display("FAIL abort_status: got %h want 04", st); else passed++;
    checks++; if (m_irq_n !== 1'b0) $display("FAIL abort_irq: got %b want 0", m_irq_n); else passed++;
    checks++; if (m_busrq_n !== 1'b1) $display("FAIL abort_busrq: got %b want 1", m_busrq_n); else passed++;
    rd16(4, v);
    checks++; if (v !== 16'd4) $display("FAIL abort_len: got %h want 0004", v); else passed++;
    cpu_wr(7, 0);
    cpu_rd(7, st);
    checks++; if (st !== 8'h00 || m_irq_n !== 1'b1) $display("FAIL abort_clear: got %h/%b want 00/1", st, m_irq_n); else passed++;
    arb_hold = 0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    logic [7:0] st;
    gdelay = 0;
    start_xfer(16'h3000, 16'h5000, 16'd3, 1, 0, 0);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = !m_wr_n;
    end
    checks++; if (!seen) $display("FAIL rstmid_wr_start: got wr_n high want low"); else passed++;
    #1 reset_n = 0;
    #1;
    checks++; if ({m_busrq_n, m_wr_n, m_oe} !== 3'b110) $display("FAIL rstmid_release: got %b want 110", {m_busrq_n, m_wr_n, m_oe}); else passed++;
    @(negedge clk);
    reset_n = 1;
    cpu_rd(7, st);
    checks++; if (st !== 8'h00) $display("FAIL rstmid_status: got %h want 00", st); else passed++;
    checks++; if (m_irq_n !== 1'b1) $display("FAIL rstmid_irq: got %b want 1", m_irq_n); else passed++;
    cpu_rd(0, st);
    checks++; if (st !== 8'h00) $display("FAIL rstmid_src: got %h want 00", st); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_random();
    test_burst();
    test_bus_loss();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
